// File: rtl/gray_frame_tx.sv
// gray_frame_tx
//   Gray-level test-pattern source. Emits a 36-bit frame-size control word
//   on out1, then one frame of 8-bit pixels on out0 (Avalon-ST, sop/eop,
//   ready backpressure). It then idles for a programmable gap and repeats
//   while enabled. Configuration and status live on an Avalon-MM slave.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   avs_s0_*                   register slave (addr 0 CTRL, 1 SIZE, 2 PAT, 3 STATUS)
//   aso_out0_*                 pixel stream (data/valid/ready/sop/eop)
//   aso_out1_data/valid        {width, height, 4'b0} control word strobe
//   frame_done                 one-cycle pulse after the eop beat is accepted
module gray_frame_tx #(
   parameter int unsigned W   = 960,
   parameter int unsigned H   = 540,
   parameter int unsigned GAP = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  avs_s0_address,
   input  logic        avs_s0_write,
   input  logic [31:0] avs_s0_writedata,
   input  logic        avs_s0_read,
   output logic [31:0] avs_s0_readdata,
   output logic [7:0]  aso_out0_data,
   output logic        aso_out0_valid,
   input  logic        aso_out0_ready,
   output logic        aso_out0_startofpacket,
   output logic        aso_out0_endofpacket,
   output logic [35:0] aso_out1_data,
   output logic        aso_out1_valid,
   output logic        frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_CTRL, S_PIX, S_GAP} state_t;

   state_t      state, state_nxt;

   // programmable registers
   logic        enable, oneshot, err;
   logic [1:0]  mode;
   logic [15:0] width, height, gap;
   logic [7:0]  value;
   logic [15:0] frame_count;

   // per-frame shadow copies, frozen while a frame is in flight
   logic [1:0]  s_mode;
   logic [15:0] s_width, s_height, s_gap;
   logic [7:0]  s_value;

   logic [15:0] x, y, gap_cnt;
   logic [7:0]  pix;
   logic        accept, last_x, last_y, eop_accept, size_bad, enter_ctrl;
   logic        wr_ctrl, wr_size, wr_pat;

   assign wr_ctrl    = avs_s0_write && (avs_s0_address == 2'd0);
   assign wr_size    = avs_s0_write && (avs_s0_address == 2'd1);
   assign wr_pat     = avs_s0_write && (avs_s0_address == 2'd2);
   assign size_bad   = (width == '0) || (height == '0);
   assign last_x     = (x == s_width - 16'd1);
   assign last_y     = (y == s_height - 16'd1);
   assign accept     = (state == S_PIX) && aso_out0_ready;
   assign eop_accept = accept && last_x && last_y;
   assign enter_ctrl = (state_nxt == S_CTRL) && (state != S_CTRL);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (enable && !size_bad) state_nxt = S_CTRL;
         S_CTRL: state_nxt = S_PIX;
         S_PIX: begin
            if (eop_accept) begin
               // a zero gap skips S_GAP; the oneshot auto-clear is not yet
               // visible in enable, so account for it here
               if (s_gap == '0) state_nxt = (enable && !oneshot) ? S_CTRL : S_IDLE;
               else             state_nxt = S_GAP;
            end
         end
         S_GAP: if (gap_cnt == 16'd1) state_nxt = enable ? S_CTRL : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // pixel pattern from the current coordinates; x/y only move on acceptance
   always_comb begin
      pix = '0;
      case (s_mode)
         2'd0: pix = x[7:0] + frame_count[7:0];
         2'd1: pix = y[7:0];
         2'd2: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
         2'd3: pix = s_value;
         default: pix = '0;
      endcase
   end

   // outputs
   always_comb begin
      aso_out0_valid         = 1'b0;
      aso_out0_data          = '0;
      aso_out0_startofpacket = 1'b0;
      aso_out0_endofpacket   = 1'b0;
      aso_out1_valid         = 1'b0;
      aso_out1_data          = '0;
      case (state)
         S_CTRL: begin
            aso_out1_valid = 1'b1;
            aso_out1_data  = {s_width, s_height, 4'b0};
         end
         S_PIX: begin
            aso_out0_valid         = 1'b1;
            aso_out0_data          = pix;
            aso_out0_startofpacket = (x == '0) && (y == '0);
            aso_out0_endofpacket   = last_x && last_y;
         end
         default: ;
      endcase
   end

   // register file, status and readback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable          <= 1'b0;
         oneshot         <= 1'b0;
         mode            <= '0;
         width           <= 16'(W);
         height          <= 16'(H);
         value           <= '0;
         gap             <= 16'(GAP);
         err             <= 1'b0;
         frame_count     <= '0;
         frame_done      <= 1'b0;
         avs_s0_readdata <= '0;
      end else begin
         frame_done <= eop_accept;
         if (eop_accept) begin
            frame_count <= frame_count + 16'd1;
            if (oneshot) enable <= 1'b0;
         end
         // a CTRL write in the same cycle overrides the oneshot auto-clear
         if (wr_ctrl) begin
            enable  <= avs_s0_writedata[0];
            oneshot <= avs_s0_writedata[1];
            mode    <= avs_s0_writedata[3:2];
         end
         if (state == S_IDLE && enable && size_bad) err <= 1'b1;
         if (wr_size) begin
            width  <= avs_s0_writedata[15:0];
            height <= avs_s0_writedata[31:16];
            if (avs_s0_writedata[15:0] != '0 && avs_s0_writedata[31:16] != '0) err <= 1'b0;
         end
         if (wr_pat) begin
            value <= avs_s0_writedata[7:0];
            gap   <= avs_s0_writedata[31:16];
         end
         if (avs_s0_read) begin
            case (avs_s0_address)
               2'd0: avs_s0_readdata <= {28'b0, mode, oneshot, enable};
               2'd1: avs_s0_readdata <= {height, width};
               2'd2: avs_s0_readdata <= {gap, 8'b0, value};
               default: avs_s0_readdata <= {frame_count, 13'b0, err, (state != S_IDLE), enable};
            endcase
         end
      end
   end

   // frame datapath: shadows, coordinates, gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_mode   <= '0;
         s_width  <= '0;
         s_height <= '0;
         s_gap    <= '0;
         s_value  <= '0;
         x        <= '0;
         y        <= '0;
         gap_cnt  <= '0;
      end else begin
         if (enter_ctrl) begin
            s_mode   <= mode;
            s_width  <= width;
            s_height <= height;
            s_gap    <= gap;
            s_value  <= value;
         end
         if (state == S_CTRL) begin
            x <= '0;
            y <= '0;
         end else if (accept) begin
            if (last_x) begin
               x <= '0;
               y <= y + 16'd1;
            end else begin
               x <= x + 16'd1;
            end
         end
         if (eop_accept)          gap_cnt <= s_gap;
         else if (state == S_GAP) gap_cnt <= gap_cnt - 16'd1;
      end
   end

endmodule

// File: tb/tb_gray_frame_tx.sv
module tb_gray_frame_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  avs_s0_address = '0;
   logic        avs_s0_write = 1'b0;
   logic [31:0] avs_s0_writedata = '0;
   logic        avs_s0_read = 1'b0;
   logic [31:0] avs_s0_readdata;
   logic [7:0]  aso_out0_data;
   logic        aso_out0_valid;
   logic        aso_out0_ready = 1'b1;
   logic        aso_out0_startofpacket;
   logic        aso_out0_endofpacket;
   logic [35:0] aso_out1_data;
   logic        aso_out1_valid;
   logic        frame_done;

   gray_frame_tx #(.W(960), .H(540), .GAP(16)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .avs_s0_address         (avs_s0_address),
      .avs_s0_write           (avs_s0_write),
      .avs_s0_writedata       (avs_s0_writedata),
      .avs_s0_read            (avs_s0_read),
      .avs_s0_readdata        (avs_s0_readdata),
      .aso_out0_data          (aso_out0_data),
      .aso_out0_valid         (aso_out0_valid),
      .aso_out0_ready         (aso_out0_ready),
      .aso_out0_startofpacket (aso_out0_startofpacket),
      .aso_out0_endofpacket   (aso_out0_endofpacket),
      .aso_out1_data          (aso_out1_data),
      .aso_out1_valid         (aso_out1_valid),
      .frame_done             (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   logic [9:0]  beat_q[$];   // {sop, eop, data}
   logic [9:0]  exp_q[$];
   logic [35:0] ctrl_q[$];
   int          ctrl_cyc[$];
   int          eop_cyc[$];
   int          done_cyc[$];
   int          cyc = 0;
   logic        stall_pend = 1'b0;
   logic [9:0]  held;

   always @(negedge clk) begin
      cyc++;
      if (aso_out1_valid) begin
         ctrl_q.push_back(aso_out1_data);
         ctrl_cyc.push_back(cyc);
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (stall_pend && aso_out0_valid)
         check_val("stall_hold",
                   {aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data}, held);
      if (aso_out0_valid && aso_out0_ready) begin
         beat_q.push_back({aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data});
         if (aso_out0_endofpacket) eop_cyc.push_back(cyc);
      end
      stall_pend = aso_out0_valid && !aso_out0_ready;
      held = {aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data};
   end

   // ---------------- stimulus helpers ----------------
   int rdy_mode = 0;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
   int rdy_ph   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         1: begin aso_out0_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
         2: aso_out0_ready = ($urandom_range(0, 9) < 7);
         default: aso_out0_ready = 1'b1;
      endcase
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
      tick();
      avs_s0_write = 1'b0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      avs_s0_address = a; avs_s0_read = 1'b1;
      tick();
      avs_s0_read = 1'b0;
      d = avs_s0_readdata;
   endtask

   task automatic clear_mon();
      beat_q.delete(); exp_q.delete(); ctrl_q.delete();
      ctrl_cyc.delete(); eop_cyc.delete(); done_cyc.delete();
   endtask

   // reference model: one frame of beats, frame counter tracked separately
   int fc_m = 0;

   task automatic build_frame(input int w, input int h, input int md, input int val);
      logic [7:0] d;
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++) begin
            case (md)
               0: d = 8'((xx + fc_m) % 256);
               1: d = 8'(yy % 256);
               2: d = (((xx / 8) + (yy / 8)) % 2 == 1) ? 8'hFF : 8'h00;
               default: d = 8'(val);
            endcase
            exp_q.push_back({(xx == 0 && yy == 0), (xx == w - 1 && yy == h - 1), d});
         end
      fc_m = (fc_m + 1) % 65536;
   endtask

   task automatic cmp_beats(input string tag);
      check_val({tag, "_nbeats"}, 64'(beat_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++)
         check_val($sformatf("%s_beat%0d", tag, i), beat_q[i], exp_q[i]);
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int k = 0;
      while (done_cyc.size() < n && k < budget) begin tick(); k++; end
      check_val({tag, "_done_in_time"}, 64'(done_cyc.size() >= n), 1);
   endtask

   task automatic wait_ctrl(input int n, input int budget, input string tag);
      int k = 0;
      while (ctrl_q.size() < n && k < budget) begin tick(); k++; end
      check_val({tag, "_ctrl_in_time"}, 64'(ctrl_q.size() >= n), 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] rd;
      int w, h, md, val, gp;

      ticks(3);
      check_val("rst_outputs",
                {aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data,
                 aso_out1_valid, aso_out1_data, frame_done, avs_s0_readdata}, '0);
      rst_n = 1'b1;
      tick();
      reg_rd(2'd1, rd); check_val("rst_size", rd, {16'd540, 16'd960});
      reg_rd(2'd2, rd); check_val("rst_pat", rd, {16'd16, 16'd0});
      reg_rd(2'd3, rd); check_val("rst_status", rd, 0);
      reg_rd(2'd0, rd); check_val("rst_ctrl", rd, 0);

      // ramp-x 4x2 oneshot, always ready
      reg_wr(2'd2, 32'h0002_0000);
      reg_wr(2'd1, 32'h0002_0004);
      clear_mon();
      build_frame(4, 2, 0, 0);
      reg_wr(2'd0, 32'h3);
      wait_done(1, 200, "t1");
      ticks(6);
      cmp_beats("t1");
      check_val("t1_nctrl", 64'(ctrl_q.size()), 1);
      if (ctrl_q.size() > 0) check_val("t1_ctrl_word", ctrl_q[0], 36'h000400020);
      if (eop_cyc.size() > 0 && done_cyc.size() > 0)
         check_val("t1_done_timing", 64'(done_cyc[0]), 64'(eop_cyc[0] + 1));
      check_val("t1_done_pulses", 64'(done_cyc.size()), 1);
      reg_rd(2'd0, rd); check_val("t1_enable_cleared", rd[0], 0);
      reg_rd(2'd3, rd); check_val("t1_status", rd, {16'(fc_m), 16'd0});

      // same frame, ready 1,0,0,1 repeating
      rdy_mode = 1; rdy_ph = 0;
      clear_mon();
      build_frame(4, 2, 0, 0);
      reg_wr(2'd0, 32'h3);
      wait_done(1, 300, "t2");
      ticks(6);
      cmp_beats("t2");
      rdy_mode = 0;

      // continuous, gap=3, two frames; enable cleared during frame 2
      reg_wr(2'd2, 32'h0003_0000);
      clear_mon();
      build_frame(4, 2, 0, 0);
      build_frame(4, 2, 0, 0);
      reg_wr(2'd0, 32'h1);
      wait_ctrl(2, 200, "t3");
      reg_wr(2'd0, 32'h0);
      wait_done(2, 200, "t3");
      ticks(10);
      cmp_beats("t3");
      check_val("t3_nctrl", 64'(ctrl_q.size()), 2);
      if (ctrl_cyc.size() > 1 && eop_cyc.size() > 0)
         check_val("t3_gap_cycles", 64'(ctrl_cyc[1] - eop_cyc[0] - 1), 3);

      // SIZE write mid-frame
      clear_mon();
      build_frame(4, 2, 0, 0);
      build_frame(8, 8, 0, 0);
      reg_wr(2'd0, 32'h1);
      begin
         int k = 0;
         while (beat_q.size() < 3 && k < 100) begin tick(); k++; end
      end
      reg_wr(2'd1, 32'h0008_0008);
      wait_ctrl(2, 200, "t4");
      reg_wr(2'd0, 32'h0);
      wait_done(2, 400, "t4");
      ticks(10);
      cmp_beats("t4");
      if (ctrl_q.size() > 1) check_val("t4_ctrl_word2", ctrl_q[1], 36'h000800080);

      // zero width: error, no traffic; valid SIZE clears err and frame follows
      reg_wr(2'd1, 32'h0002_0000);
      clear_mon();
      reg_wr(2'd0, 32'h3);
      ticks(10);
      check_val("t5_no_ctrl", 64'(ctrl_q.size()), 0);
      check_val("t5_no_beats", 64'(beat_q.size()), 0);
      reg_rd(2'd3, rd); check_val("t5_status_err", rd, {16'(fc_m), 13'd0, 3'b101});
      build_frame(2, 2, 0, 0);
      reg_wr(2'd1, 32'h0002_0002);
      wait_done(1, 200, "t5");
      ticks(8);
      cmp_beats("t5");
      reg_rd(2'd3, rd); check_val("t5_err_cleared", rd[2], 0);

      // randomized oneshot frames under random backpressure
      rdy_mode = 2;
      for (int it = 0; it < 8; it++) begin
         w = $urandom_range(1, 9); h = $urandom_range(1, 5);
         md = $urandom_range(0, 3); val = $urandom_range(0, 255); gp = $urandom_range(0, 3);
         reg_wr(2'd2, {16'(gp), 8'd0, 8'(val)});
         reg_wr(2'd1, {16'(h), 16'(w)});
         clear_mon();
         build_frame(w, h, md, val);
         reg_wr(2'd0, {28'd0, 2'(md), 2'b11});
         wait_done(1, 2000, $sformatf("rnd%0d", it));
         ticks(gp + 6);
         cmp_beats($sformatf("rnd%0d", it));
         if (ctrl_q.size() > 0)
            check_val($sformatf("rnd%0d_ctrl", it), ctrl_q[0], {16'(w), 16'(h), 4'd0});
         reg_rd(2'd3, rd);
         check_val($sformatf("rnd%0d_status", it), rd, {16'(fc_m), 16'd0});
      end
      rdy_mode = 0;

      // reset during beat 3
      reg_wr(2'd2, 32'h0002_0000);
      reg_wr(2'd1, 32'h0002_0004);
      clear_mon();
      reg_wr(2'd0, 32'h3);
      begin
         int k = 0;
         while (beat_q.size() < 2 && k < 100) begin tick(); k++; end
         check_val("t6_reached_beat3", 64'(beat_q.size()), 2);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_val("t6_rst_outputs",
                {aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data,
                 aso_out1_valid, aso_out1_data, frame_done}, '0);
      tick();
      rst_n = 1'b1;
      fc_m = 0;
      clear_mon();
      reg_rd(2'd3, rd); check_val("t6_status", rd, 0);
      ticks(10);
      check_val("t6_no_beats", 64'(beat_q.size()), 0);
      check_val("t6_no_ctrl", 64'(ctrl_q.size()), 0);
      check_val("t6_no_eop", 64'(eop_cyc.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_frame_tx.md
Name: gray_frame_tx

Overview:
- Transmit-side counterpart of the histogram-equalisation gray pipeline.
- Generates 8-bit gray video frames on an Avalon-ST source, with sop/eop, and honours ready backpressure.
- Emits the 36-bit frame-size control word {width, height, 4'b0} on a companion channel before each frame.
- Configured via an Avalon-MM slave; used as a pattern source feeding the equalisation block in bring-up and regression.

Parameters:
- W, 960, reset frame width in pixels.
- H, 540, reset frame height in lines.
- GAP, 16, reset inter-frame idle cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- avs_s0_address  in  2  register address.
- avs_s0_write  in  1  register write strobe.
- avs_s0_writedata  in  32  write data.
- avs_s0_read  in  1  register read strobe.
- avs_s0_readdata  out  32  read data, registered, valid the cycle after avs_s0_read.
- aso_out0_data  out  8  gray pixel.
- aso_out0_valid  out  1  pixel valid.
- aso_out0_ready  in  1  downstream ready.
- aso_out0_startofpacket  out  1  first pixel of frame.
- aso_out0_endofpacket  out  1  last pixel of frame.
- aso_out1_data  out  36  control word {width[15:0], height[15:0], 4'b0}.
- aso_out1_valid  out  1  one-cycle control word strobe.
- frame_done  out  1  one-cycle pulse when the last pixel is accepted.

Behaviour:
- Reset: all outputs 0, FSM IDLE.
  - Registers: enable=0, oneshot=0, mode=0, width=W, height=H, value=0, gap=GAP.
  - frame_count=0, err=0.
- Register map, writes taking effect next cycle:
  - 0 CTRL: [0] enable, [1] oneshot, [3:2] mode.
  - 1 SIZE: [31:16] height, [15:0] width.
  - 2 PAT: [7:0] value, [31:16] gap.
  - 3 STATUS, read-only: [31:16] frame_count, [2] err, [1] busy (state != IDLE), [0] enable. Writes to address 3 are ignored.
- Shadow copies of width, height, mode, value and gap are latched on entry to CTRL. Register writes during a frame never affect the frame in flight.
- FSM transitions:
  - IDLE -> CTRL when enable=1.
    - If width==0 or height==0: stay IDLE and set err. err clears when a SIZE write has both fields nonzero.
  - CTRL, 1 cycle: aso_out1_valid=1, aso_out1_data={width,height,4'b0}; x=0, y=0. Then -> PIX.
  - PIX: aso_out0_valid=1 continuously.
    - A beat is accepted on valid&&ready. On acceptance, x increments. When x wraps at width-1, x=0 and y increments.
    - When !ready, data, sop and eop hold stable.
    - sop=1 only when x==0 and y==0. eop=1 only when x==width-1 and y==height-1.
    - On acceptance of the eop beat: frame_done=1 for one cycle, frame_count+=1 (wraps at 16 bits), -> GAP.
  - GAP: valid=0 for gap cycles (gap=0 means zero idle cycles).
    - At the end of GAP: if enable=1 -> CTRL, else -> IDLE.
- oneshot=1: enable auto-clears on frame_done.
- Clearing enable mid-frame does not abort the frame: the current frame completes, then the block idles.
- Pixel data, registered and combinationally stable while stalled:
  - mode0 ramp-x: x[7:0] + frame_count[7:0].
  - mode1 ramp-y: y[7:0].
  - mode2 checker: (x[3]^y[3]) ? 8'hFF : 8'h00.
  - mode3 constant: value.
- Latency: the first pixel is valid the cycle after the CTRL strobe, and at least 1 cycle after enable is set.
- Simultaneous write to CTRL with frame_done in oneshot mode: the register write wins.
- rst_n asserted mid-frame: immediate return to reset state, valid drops asynchronously, no eop is emitted.

Test Plan:
- Ramp-x, width=4, height=2, ready=1, enable+oneshot:
  - ctrl word 0x000400020 once.
  - 8 beats with data 0,1,2,3,0,1,2,3; sop on beat 1, eop on beat 8.
  - frame_done one cycle after beat 8; enable reads 0; frame_count=1.
- Same frame, ready toggling 1,0,0,1 repeating: data/sop/eop constant across stalls, exactly 8 accepted beats, same sequence.
- Continuous mode, gap=3, two frames of ramp-x 4x2:
  - exactly 3 idle cycles between the eop beat and the second ctrl strobe.
  - second frame data is 1,2,3,4,1,2,3,4.
- SIZE write of 8x8 mid-frame: the current 4x2 frame still ends after 8 beats; the next ctrl word is 0x000800080.
- width=0 with enable set: no ctrl strobe, valid stays 0, STATUS err=1. Writing SIZE 2x2 clears err, and a 4-beat frame follows.
- rst_n low during beat 3: all outputs 0 next edge. After release with enable=0: STATUS reads 0 and no traffic.
